// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 16x oversampling, feeding a first-word
// fall-through byte FIFO.
//
// Parameters
//   BAUD_DIV   clk cycles per 16x oversampling tick (1..65535)
//   FIFO_AW    FIFO address width; depth is 2**FIFO_AW bytes
//
// Ports
//   clk        system clock, rising-edge active
//   reset_pin  asynchronous active-low reset
//   rx         asynchronous serial input, idles high, LSB first
//   rd_rx_pin  active-low pop strobe, one byte per clk while low and not empty
//   r_data     FIFO head byte, 8'h00 while empty
//   rx_empty   FIFO holds no bytes
//   rx_full    FIFO holds 2**FIFO_AW bytes
//   rx_busy    receiver FSM is not idle
//   frame_err  one-cycle pulse: stop bit sampled low, byte discarded
//   overrun    one-cycle pulse: good byte dropped because the FIFO was full
module uart_rx_fifo #(
    parameter int unsigned BAUD_DIV = 163,
    parameter int unsigned FIFO_AW  = 4
) (
    input  logic       clk,
    input  logic       reset_pin,
    input  logic       rx,
    input  logic       rd_rx_pin,
    output logic [7:0] r_data,
    output logic       rx_empty,
    output logic       rx_full,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned Depth   = 1 << FIFO_AW;
    localparam logic [15:0] BaudMax = 16'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizer (resets to the idle line level)
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;

    always_ff @(posedge clk or negedge reset_pin) begin
        if (!reset_pin) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Free-running oversampling tick
    // ------------------------------------------------------------------
    logic [15:0] r_baud_cnt;
    logic        w_tick;

    assign w_tick = (r_baud_cnt == BaudMax);

    always_ff @(posedge clk or negedge reset_pin) begin
        if (!reset_pin) begin
            r_baud_cnt <= 16'd0;
        end else if (w_tick) begin
            r_baud_cnt <= 16'd0;
        end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    state_e     r_state;
    state_e     w_state_next;
    logic [3:0] r_s_cnt;
    logic [3:0] w_s_cnt_next;
    logic [2:0] r_n_cnt;
    logic [2:0] w_n_cnt_next;
    logic [7:0] r_shift;
    logic [7:0] w_shift_next;
    logic       w_push;
    logic       w_ferr;

    always_ff @(posedge clk or negedge reset_pin) begin
        if (!reset_pin) begin
            r_state <= StIdle;
            r_s_cnt <= 4'd0;
            r_n_cnt <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_s_cnt <= w_s_cnt_next;
            r_n_cnt <= w_n_cnt_next;
            r_shift <= w_shift_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_s_cnt_next = r_s_cnt;
        w_n_cnt_next = r_n_cnt;
        w_shift_next = r_shift;
        w_push       = 1'b0;
        w_ferr       = 1'b0;
        unique case (r_state)
            StIdle: begin
                // Start-bit edge is acted on immediately, not on a tick.
                if (!r_rx_sync) begin
                    w_state_next = StStart;
                    w_s_cnt_next = 4'd0;
                end
            end
            StStart: begin
                if (w_tick) begin
                    if (r_s_cnt == 4'd7) begin
                        // Mid start bit: a high line here was only a glitch.
                        if (!r_rx_sync) begin
                            w_state_next = StData;
                            w_s_cnt_next = 4'd0;
                            w_n_cnt_next = 3'd0;
                        end else begin
                            w_state_next = StIdle;
                        end
                    end else begin
                        w_s_cnt_next = r_s_cnt + 4'd1;
                    end
                end
            end
            StData: begin
                if (w_tick) begin
                    if (r_s_cnt == 4'd15) begin
                        w_shift_next = {r_rx_sync, r_shift[7:1]};
                        w_s_cnt_next = 4'd0;
                        if (r_n_cnt == 3'd7) begin
                            w_state_next = StStop;
                        end else begin
                            w_n_cnt_next = r_n_cnt + 3'd1;
                        end
                    end else begin
                        w_s_cnt_next = r_s_cnt + 4'd1;
                    end
                end
            end
            StStop: begin
                if (w_tick) begin
                    if (r_s_cnt == 4'd15) begin
                        w_state_next = StIdle;
                        if (r_rx_sync) begin
                            w_push = 1'b1;
                        end else begin
                            w_ferr = 1'b1;
                        end
                    end else begin
                        w_s_cnt_next = r_s_cnt + 4'd1;
                    end
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign rx_busy = (r_state != StIdle);

    // ------------------------------------------------------------------
    // FIFO: extra pointer MSB distinguishes full from empty
    // ------------------------------------------------------------------
    logic [7:0]       r_mem [Depth];
    logic [FIFO_AW:0] r_wptr;
    logic [FIFO_AW:0] r_rptr;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_wr_en;
    logic             w_overrun;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                       (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
    assign w_pop     = !rd_rx_pin && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr_en   = w_push && (!w_full || w_pop);
    assign w_overrun = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr[FIFO_AW-1:0]] <= r_shift;
        end
    end

    always_ff @(posedge clk or negedge reset_pin) begin
        if (!reset_pin) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Storage is not reset, so mask it while empty.
    assign r_data   = w_empty ? 8'h00 : r_mem[r_rptr[FIFO_AW-1:0]];
    assign rx_empty = w_empty;
    assign rx_full  = w_full;

    // ------------------------------------------------------------------
    // Status pulses
    // ------------------------------------------------------------------
    logic r_frame_err;
    logic r_overrun;

    always_ff @(posedge clk or negedge reset_pin) begin
        if (!reset_pin) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_overrun   <= w_overrun;
        end
    end

    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo at BAUD_DIV=2 (32 clk per
// bit). Frames are driven cycle by cycle; the edge on which the STOP decision
// lands is computed from the free-running tick phase so that the push edge
// can be probed and, when needed, hit with a simultaneous pop.
module tb_uart_rx_fifo;

    localparam int BaudDiv = 2;
    localparam int BitClk  = 16 * BaudDiv;

    logic       clk;
    logic       reset_pin;
    logic       rx;
    logic       rd_rx_pin;
    logic [7:0] r_data;
    logic       rx_empty;
    logic       rx_full;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    uart_rx_fifo #(
        .BAUD_DIV (BaudDiv),
        .FIFO_AW  (4)
    ) u_dut (
        .clk       (clk),
        .reset_pin (reset_pin),
        .rx        (rx),
        .rd_rx_pin (rd_rx_pin),
        .r_data    (r_data),
        .rx_empty  (rx_empty),
        .rx_full   (rx_full),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Clock edges since reset release; edge k carries a tick when k % BaudDiv == 0.
    int cyc;
    always @(posedge clk or negedge reset_pin) begin
        if (!reset_pin) cyc <= 0;
        else            cyc <= cyc + 1;
    end

    // Pulse / busy monitors, sampled mid-cycle.
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int busy_cyc = 0;
    always @(negedge clk) begin
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (overrun)   ovr_cnt  <= ovr_cnt + 1;
        if (rx_busy)   busy_cyc <= busy_cyc + 1;
    end

    // Observations captured around the STOP decision edge of the last frame.
    logic empty_pre, busy_pre;
    logic empty_post, busy_post, full_post, ferr_post, ovr_post;
    int   busy_len, busy_exp;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic int first_tick(input int e);
        return e + (BaudDiv - (e % BaudDiv));
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_byte();
        @(posedge clk);
        #1 rd_rx_pin = 1'b0;
        @(posedge clk);
        #1 rd_rx_pin = 1'b1;
    endtask

    // Start edge ea: synchronized low seen at ea+3 (FSM enters START), then
    // 8 + 8*16 + 16 = 152 ticks to the STOP decision edge d.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input logic pop_at_push);
        logic [9:0] frame;
        int ea, e0, d, snap;
        frame = {stop_bit, data, 1'b0};
        @(posedge clk);
        #1;
        ea   = cyc;
        snap = busy_cyc;
        rx   = 1'b0;
        e0   = ea + 3;
        d    = first_tick(e0) + 151 * BaudDiv;
        for (int n = 1; n < 10 * BitClk; n++) begin
            @(posedge clk);
            #1;
            rx        = frame[n / BitClk];
            rd_rx_pin = !(pop_at_push && (ea + n == d - 1));
            if (ea + n == d - 1) begin
                empty_pre = rx_empty;
                busy_pre  = rx_busy;
            end
            if (ea + n == d) begin
                empty_post = rx_empty;
                busy_post  = rx_busy;
                full_post  = rx_full;
                ferr_post  = frame_err;
                ovr_post   = overrun;
                busy_len   = busy_cyc - snap;
            end
        end
        rx       = 1'b1;
        busy_exp = d - e0;
    endtask

    initial begin
        int ea, snap_b, snap_f, snap_o;
        logic [9:0] frame;
        logic [7:0] exp_b;

        reset_pin = 1'b0;
        rx        = 1'b1;
        rd_rx_pin = 1'b1;
        idle(3);
        check_eq("rst_empty", rx_empty, 1);
        check_eq("rst_full", rx_full, 0);
        check_eq("rst_busy", rx_busy, 0);
        check_eq("rst_ferr", frame_err, 0);
        check_eq("rst_ovr", overrun, 0);
        check_eq("rst_data", r_data, 8'h00);
        reset_pin = 1'b1;
        idle(5);

        // Single good frame 0x41
        send_frame(8'h41, 1'b1, 1'b0);
        check_eq("41_busy_pre", busy_pre, 1);
        check_eq("41_busy_post", busy_post, 0);
        check_eq("41_busy_len", busy_len, busy_exp);
        check_eq("41_empty_pre", empty_pre, 1);
        check_eq("41_empty_post", empty_post, 0);
        check_eq("41_data", r_data, 8'h41);
        pop_byte();
        check_eq("41_pop_empty", rx_empty, 1);
        check_eq("41_pop_data", r_data, 8'h00);
        pop_byte();
        check_eq("pop_when_empty", rx_empty, 1);
        check_eq("pop_when_empty_full", rx_full, 0);

        // 10-cycle glitch: START entered at ea+3, rejected at the 8th tick
        snap_b = busy_cyc;
        snap_f = ferr_cnt;
        snap_o = ovr_cnt;
        @(posedge clk);
        #1;
        ea = cyc;
        rx = 1'b0;
        repeat (10) @(posedge clk);
        #1 rx = 1'b1;
        idle(60);
        check_eq("glitch_busy", rx_busy, 0);
        check_eq("glitch_empty", rx_empty, 1);
        check_eq("glitch_busy_len", busy_cyc - snap_b,
                 first_tick(ea + 3) + 7 * BaudDiv - (ea + 3));
        check_eq("glitch_ferr", ferr_cnt - snap_f, 0);
        check_eq("glitch_ovr", ovr_cnt - snap_o, 0);

        // Frame 0x28 with a low stop bit
        snap_f = ferr_cnt;
        send_frame(8'h28, 1'b0, 1'b0);
        check_eq("ferr_pulse", ferr_post, 1);
        check_eq("ferr_empty_post", empty_post, 1);
        idle(60);
        check_eq("ferr_count", ferr_cnt - snap_f, 1);
        check_eq("ferr_empty", rx_empty, 1);
        check_eq("ferr_busy", rx_busy, 0);

        // 17 bytes without reading: fill, then one overrun
        snap_o = ovr_cnt;
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, 1'b0);
            if (i == 14) check_eq("fill15_full", full_post, 0);
            if (i == 15) check_eq("fill16_full", full_post, 1);
            if (i == 16) begin
                check_eq("byte17_ovr", ovr_post, 1);
                check_eq("byte17_full", full_post, 1);
            end
        end
        idle(5);
        check_eq("ovr_count", ovr_cnt - snap_o, 1);
        for (int i = 0; i < 16; i++) begin
            check_eq("drain_data", r_data, 32'(i));
            pop_byte();
        end
        check_eq("drain_empty", rx_empty, 1);

        // Full FIFO with a pop landing on the push edge
        for (int i = 0; i < 16; i++) send_frame(8'h80 + 8'(i), 1'b1, 1'b0);
        check_eq("refill_full", rx_full, 1);
        snap_o = ovr_cnt;
        send_frame(8'hA5, 1'b1, 1'b1);
        check_eq("pushpop_ovr", ovr_post, 0);
        check_eq("pushpop_full", full_post, 1);
        idle(5);
        check_eq("pushpop_ovr_cnt", ovr_cnt - snap_o, 0);
        for (int i = 0; i < 16; i++) begin
            exp_b = (i < 15) ? 8'h81 + 8'(i) : 8'hA5;
            check_eq("pushpop_data", r_data, exp_b);
            pop_byte();
        end
        check_eq("pushpop_empty", rx_empty, 1);

        // Reset during data bit 4 with a byte already queued
        send_frame(8'h55, 1'b1, 1'b0);
        frame = {1'b1, 8'h3C, 1'b0};
        @(posedge clk);
        #1 rx = 1'b0;
        for (int n = 1; n <= 5 * BitClk + BitClk / 2; n++) begin
            @(posedge clk);
            #1 rx = frame[n / BitClk];
        end
        check_eq("midrst_pre_busy", rx_busy, 1);
        check_eq("midrst_pre_empty", rx_empty, 0);
        reset_pin = 1'b0;
        #1;
        check_eq("midrst_busy", rx_busy, 0);
        check_eq("midrst_empty", rx_empty, 1);
        check_eq("midrst_full", rx_full, 0);
        check_eq("midrst_data", r_data, 8'h00);
        check_eq("midrst_ferr", frame_err, 0);
        check_eq("midrst_ovr", overrun, 0);
        idle(4);
        rx        = 1'b1;
        reset_pin = 1'b1;
        idle(10);
        check_eq("postrst_empty", rx_empty, 1);
        send_frame(8'h08, 1'b1, 1'b0);
        check_eq("postrst_push", empty_post, 0);
        check_eq("postrst_data", r_data, 8'h08);
        pop_byte();
        check_eq("postrst_drained", rx_empty, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter BAUD_DIV, default 163: clk cycles per 16x oversampling tick; legal range 1..65535.
REQ-002 Parameter FIFO_AW, default 4: FIFO address width, giving a depth of 2**FIFO_AW = 16 bytes.
REQ-003 clk  input  1  single system clock; all state advances on the rising edge.
REQ-004 reset_pin  input  1  asynchronous, active-low reset.
REQ-005 rx  input  1  asynchronous serial line; idles high; 8N1 frames, LSB first.
REQ-006 rd_rx_pin  input  1  active-low read strobe; pops one byte per clk cycle while low and FIFO not empty.
REQ-007 r_data  output  8  FIFO head byte (first-word fall-through); 8'h00 when empty.
REQ-008 rx_empty  output  1  high when FIFO holds 0 bytes.
REQ-009 rx_full  output  1  high when FIFO holds 2**FIFO_AW bytes.
REQ-010 rx_busy  output  1  high whenever the receiver FSM is not in IDLE.
REQ-011 frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-012 overrun  output  1  one-cycle pulse; good byte arrived while FIFO full.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer set to 1 on reset; the FSM SHALL see only the synchronized value, giving 2 cycles of input latency.
REQ-014 The tick counter SHALL count 0..BAUD_DIV-1, assert a one-cycle tick at BAUD_DIV-1, and run freely regardless of FSM state.
REQ-015 FSM states SHALL be IDLE, START, DATA and STOP, with a 4-bit tick counter s_cnt and a 3-bit bit counter n_cnt.
REQ-016 In IDLE, a synchronized rx of 0 SHALL move the FSM to START and clear s_cnt, on any clk edge and without waiting for a tick.
REQ-017 In START, on the tick where s_cnt=7 the FSM SHALL go to DATA with s_cnt and n_cnt cleared if rx=0, and otherwise return to IDLE as a glitch, pushing nothing and flagging nothing.
REQ-018 In DATA, on each tick where s_cnt=15 the FSM SHALL shift rx into bit 7 of the shift register (shift right) and clear s_cnt; after the shift at n_cnt=7 it SHALL go to STOP, and otherwise increment n_cnt.
REQ-019 In STOP, on the tick where s_cnt=15 the FSM SHALL return to IDLE, pushing the byte if rx=1 and pulsing frame_err while discarding the byte if rx=0.
REQ-020 A pushed byte SHALL appear in the FIFO, with rx_empty low, on the cycle after the STOP decision edge.
REQ-021 A push while the FIFO is full and no pop occurs in the same cycle SHALL drop the byte, pulse overrun, and leave FIFO contents unchanged.
REQ-022 A pop while empty SHALL be ignored, with pointers unchanged.
REQ-023 A simultaneous push and pop SHALL both take effect, including when full (count unchanged, no overrun) and when empty (pop ignored, push stored).
REQ-024 Read and write pointers SHALL be FIFO_AW+1 bits wide and wrap modulo 2**(FIFO_AW+1); full is MSBs differing with the rest equal, and empty is all pointer bits equal.
REQ-025 rx_busy SHALL deassert on the same edge on which the FSM enters IDLE.

Reset
REQ-026 While reset_pin=0, asynchronously and at once: FSM to IDLE, all counters and pointers to 0, shift register to 8'h00, synchronizer to 1, outputs rx_empty=1, rx_full=0, rx_busy=0, frame_err=0, overrun=0, r_data=8'h00.
REQ-027 Reset asserted mid-frame SHALL discard the partial byte and all FIFO contents; after release the receiver waits for the next falling edge.
REQ-028 FIFO storage need not be reset; it SHALL never be visible on r_data while empty.

Verification (BAUD_DIV=2, so 1 bit = 32 clk cycles)
REQ-029 Drive frame 0x41 (start 0, data 1000_0010 LSB first, stop 1) -> rx_busy high for about 9.5 bit times, then rx_empty=0 and r_data=8'h41; a one-cycle rd_rx_pin low gives rx_empty=1 and r_data=8'h00.
REQ-030 Drive a 10-cycle low glitch on idle rx -> FSM back in IDLE, no push, frame_err and overrun stay 0.
REQ-031 Drive frame 0x28 with stop bit 0 -> one frame_err pulse and rx_empty stays 1.
REQ-032 Send 17 bytes 0x00..0x10 with no reads -> rx_full=1 after the 16th byte, one overrun pulse on the 17th, then 16 pops return 0x00..0x0F in order.
REQ-033 With the FIFO full, assert rd_rx_pin low on exactly the push cycle of the next byte -> no overrun, rx_full stays 1, and the new byte appears last.
REQ-034 Pull reset_pin low during bit 4 of a frame, then release it -> all outputs take their reset values at once, and the next full frame 0x08 is received correctly.
